wb_ctrlr: RTL

Writeback controller for the MIPS datapath: the result-side counterpart to the ALU operand-select logic. Registers each completed instruction's result and drives the register-file write port. The write data comes from one of three sources: the ALU result, extended load data from memory, or the link address PC+4. For loads it waits on a memory read-valid handshake, with a bounded timeout, and holds the upstream pipeline stalled until the load resolves.

---
 rtl/wb_ctrlr.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_ctrlr.sv
// Writeback controller: registers each completed instruction's result and drives the
// register-file write port, selecting between the ALU result, extended load data and the link address.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a new instruction; non-loads complete in one cycle
// WAIT_MEM | load outstanding, upstream stalled until rvalid or timeout
module wb_ctrlr #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              w_in_valid,
   output logic              w_in_ready,
   input  logic [DATA_W-1:0] w_alu_result,
   input  logic [DATA_W-1:0] w_pc_plus4,
   input  logic [REG_AW-1:0] w_dest_reg,
   input  logic              w_reg_write,
   input  logic              w_load_op,
   input  logic              w_link_op,
   input  logic [1:0]        w_load_size,
   input  logic              w_load_unsigned,
   input  logic [DATA_W-1:0] w_mem_rdata,
   input  logic              w_mem_rvalid,
   output logic              w_rf_we,
   output logic [REG_AW-1:0] w_rf_waddr,
   output logic [DATA_W-1:0] w_rf_wdata,
   output logic              w_stall,
   output logic              w_mem_timeout
);

   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic [REG_AW-1:0] lat_dest;
   logic [1:0]        lat_off;
   logic [1:0]        lat_size;
   logic              lat_uns;
   logic              lat_rw;
   logic              we_nxt;
   logic [REG_AW-1:0] waddr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic              tmo_nxt;
   logic              accept;

   // Big-endian lane selection; lane positions assume a 32-bit bus.
   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                 input logic [1:0] off,
                                                 input logic [1:0] size,
                                                 input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [DATA_W-1:0] r;
      case (off)
         2'd0:    b = rdata[31:24];
         2'd1:    b = rdata[23:16];
         2'd2:    b = rdata[15:8];
         default: b = rdata[7:0];
      endcase
      h = off[1] ? rdata[15:0] : rdata[31:16];
      case (size)
         2'b00:   r = {{(DATA_W-8){b[7] & ~uns}}, b};
         2'b01:   r = {{(DATA_W-16){h[15] & ~uns}}, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   assign w_in_ready = (state == IDLE);
   assign w_stall    = ~w_in_ready;
   assign accept     = w_in_valid && (state == IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      we_nxt    = 1'b0;
      waddr_nxt = w_rf_waddr;
      wdata_nxt = w_rf_wdata;
      tmo_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (w_in_valid) begin
               // Link wins over load, so a link never waits on memory.
               if (w_link_op || !w_load_op) begin
                  if (w_reg_write && (w_dest_reg != '0)) begin
                     we_nxt    = 1'b1;
                     waddr_nxt = w_dest_reg;
                     wdata_nxt = w_link_op ? w_pc_plus4 : w_alu_result;
                  end
               end else begin
                  state_nxt = WAIT_MEM;
                  cnt_nxt   = '0;
               end
            end
         end
         WAIT_MEM: begin
            if (w_mem_rvalid) begin
               state_nxt = IDLE;
               if (lat_rw && (lat_dest != '0)) begin
                  we_nxt    = 1'b1;
                  waddr_nxt = lat_dest;
                  wdata_nxt = load_ext(w_mem_rdata, lat_off, lat_size, lat_uns);
               end
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               tmo_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         w_rf_we       <= 1'b0;
         w_rf_waddr    <= '0;
         w_rf_wdata    <= '0;
         w_mem_timeout <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         w_rf_we       <= we_nxt;
         w_rf_waddr    <= waddr_nxt;
         w_rf_wdata    <= wdata_nxt;
         w_mem_timeout <= tmo_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_dest <= '0;
         lat_off  <= '0;
         lat_size <= '0;
         lat_uns  <= 1'b0;
         lat_rw   <= 1'b0;
      end else if (accept) begin
         lat_dest <= w_dest_reg;
         lat_off  <= w_alu_result[1:0];
         lat_size <= w_load_size;
         lat_uns  <= w_load_unsigned;
         lat_rw   <= w_reg_write;
      end
   end

endmodule
